acondicionador_boton_largo: RTL and testbench

//  Conditions one raw push-button for the pet state machine / modes pair.

---
 rtl/acondicionador_boton_largo.sv | 104 ++++++++++
 tb/tb_acondicionador_boton_largo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/acondicionador_boton_largo.sv
// rtl/acondicionador_boton_largo.sv - push-button conditioner: sync, debounce, short/hold press pulses
module acondicionador_boton_largo #(
  parameter int DEB_CYC  = 1_000_000,
  parameter int HOLD_CYC = 250_000_000,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_raw,
  output logic boton_limpio,
  output logic pulso_corto,
  output logic pulso_5seg,
  output logic mantenido
);

  localparam int DW = $clog2(DEB_CYC);
  localparam int HW = $clog2(HOLD_CYC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } estado_t;

  logic          nivel_raw;
  logic          sync_1;
  logic          sync_2;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  estado_t       estado;

  // Normalised so that 1 always means pressed from here on.
  assign nivel_raw = ACT_LOW ? ~boton_raw : boton_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= nivel_raw;
      sync_2 <= sync_1;
    end
  end

  // The counter only runs while the synced level disagrees with the clean one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt      <= '0;
      boton_limpio <= 1'b0;
    end else if (sync_2 == boton_limpio) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
      boton_limpio <= sync_2;
      deb_cnt      <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado      <= IDLE;
      hold_cnt    <= '0;
      pulso_corto <= 1'b0;
      pulso_5seg  <= 1'b0;
      mantenido   <= 1'b0;
    end else begin
      pulso_corto <= 1'b0;
      pulso_5seg  <= 1'b0;
      case (estado)
        IDLE: begin
          if (boton_limpio) begin
            estado   <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          // Release is tested first so it wins over a coincident terminal count.
          if (!boton_limpio) begin
            estado      <= IDLE;
            pulso_corto <= 1'b1;
          end else if (hold_cnt == HW'(HOLD_CYC - 1)) begin
            estado     <= HELD;
            pulso_5seg <= 1'b1;
            mantenido  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!boton_limpio) begin
            estado    <= IDLE;
            mantenido <= 1'b0;
          end
        end
        default: begin
          estado    <= IDLE;
          mantenido <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acondicionador_boton_largo.sv
// tb/tb_acondicionador_boton_largo.sv - self-checking bench for acondicionador_boton_largo
module tb_acondicionador_boton_largo;

  localparam int DEB  = 4;
  localparam int HOLD = 20;

  logic clk;
  logic reset;
  logic boton_raw;
  logic boton_limpio;
  logic pulso_corto;
  logic pulso_5seg;
  logic mantenido;

  int checks = 0;
  int errors = 0;

  acondicionador_boton_largo #(
    .DEB_CYC (DEB),
    .HOLD_CYC(HOLD),
    .ACT_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .boton_raw   (boton_raw),
    .boton_limpio(boton_limpio),
    .pulso_corto (pulso_corto),
    .pulso_5seg  (pulso_5seg),
    .mantenido   (mantenido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pin history delayed two samples, a sliding window of
  // disagreement for the debounce, and the length of the current clean press.
  bit m_s1, m_s2, m_clean;
  int m_disagree;
  int m_press_len;
  bit m_corto, m_p5, m_mant;

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_clean = 0; m_disagree = 0;
    m_press_len = 0; m_corto = 0; m_p5 = 0; m_mant = 0;
  endtask

  task automatic model_step(input bit raw);
    bit c;
    c = m_clean;
    m_corto = 0;
    m_p5 = 0;
    if (c) begin
      m_press_len++;
      m_p5   = (m_press_len == HOLD + 1);
      m_mant = (m_press_len >= HOLD + 1);
    end else begin
      m_corto = (m_press_len >= 1) && (m_press_len <= HOLD);
      m_mant = 0;
      m_press_len = 0;
    end
    m_disagree = (m_s2 != c) ? m_disagree + 1 : 0;
    if (m_disagree == DEB) begin
      m_clean = m_s2;
      m_disagree = 0;
    end
    m_s2 = m_s1;
    m_s1 = ~raw;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input logic raw);
    boton_raw = raw;
    if (reset) model_step(raw);
    @(posedge clk);
    #1;
    chk("model_limpio", boton_limpio, m_clean);
    chk("model_corto", pulso_corto, m_corto);
    chk("model_5seg", pulso_5seg, m_p5);
    chk("model_mant", mantenido, m_mant);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    chk("rst_limpio", boton_limpio, 1'b0);
    chk("rst_corto", pulso_corto, 1'b0);
    chk("rst_5seg", pulso_5seg, 1'b0);
    chk("rst_mant", mantenido, 1'b0);
    model_clear();
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    logic raw;
    int   ncyc;
    logic e_limpio;
    logic e_corto;
    logic e_5seg;
    logic e_mant;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, int n, logic l, logic c, logic p, logic m);
    vec_t x;
    x.raw = r; x.ncyc = n; x.e_limpio = l; x.e_corto = c; x.e_5seg = p; x.e_mant = m;
    return x;
  endfunction

  initial begin
    // bounce shorter than the window
    vecs.push_back(v(0, 3, 0, 0, 0, 0));
    vecs.push_back(v(1, 8, 0, 0, 0, 0));
    // short press
    vecs.push_back(v(0, 5, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 4, 1, 0, 0, 0));
    vecs.push_back(v(1, 5, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 0, 0));
    vecs.push_back(v(1, 4, 0, 0, 0, 0));
    // long press held 60 cycles
    vecs.push_back(v(0, 6, 1, 0, 0, 0));
    vecs.push_back(v(0, 20, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 1, 1));
    vecs.push_back(v(0, 1, 1, 0, 0, 1));
    vecs.push_back(v(0, 32, 1, 0, 0, 1));
    vecs.push_back(v(1, 5, 1, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 5, 0, 0, 0, 0));
    // release lands on the terminal hold count
    vecs.push_back(v(0, 6, 1, 0, 0, 0));
    vecs.push_back(v(0, 14, 1, 0, 0, 0));
    vecs.push_back(v(1, 5, 1, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 0, 1, 0, 0));
    vecs.push_back(v(1, 3, 0, 0, 0, 0));

    boton_raw = 1'b1;
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("init_limpio", boton_limpio, 1'b0);
    chk("init_corto", pulso_corto, 1'b0);
    chk("init_5seg", pulso_5seg, 1'b0);
    chk("init_mant", mantenido, 1'b0);
    #1;
    reset = 1'b1;
    repeat (5) tick(1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].ncyc; j++) tick(vecs[i].raw);
      chk($sformatf("vec%0d_limpio", i), boton_limpio, vecs[i].e_limpio);
      chk($sformatf("vec%0d_corto", i), pulso_corto, vecs[i].e_corto);
      chk($sformatf("vec%0d_5seg", i), pulso_5seg, vecs[i].e_5seg);
      chk($sformatf("vec%0d_mant", i), mantenido, vecs[i].e_mant);
    end

    // async reset in the middle of a press, pin kept pressed afterwards
    repeat (17) tick(1'b0);
    chk("t6_pressed", boton_limpio, 1'b1);
    do_reset(2);
    begin
      int k;
      bit seen;
      k = 0;
      seen = 0;
      while (!seen && k < 60) begin
        tick(1'b0);
        k++;
        if (pulso_5seg) seen = 1;
      end
      chk_int("t6_latency", k, 2 + DEB + HOLD + 1);
    end
    repeat (10) tick(1'b1);

    // random press lengths around the debounce and hold thresholds
    for (int s = 0; s < 120; s++) begin
      logic r;
      int n;
      r = logic'($urandom_range(0, 1));
      n = (s % 3 == 0) ? $urandom_range(15, 35) : $urandom_range(1, 8);
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 3));
      for (int j = 0; j < n; j++) tick(r);
    end
    repeat (10) tick(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
